// File: rtl/nibble_add_sequencer.sv
// Two-requester adder controller that time-shares one 4-bit ripple slice,
// walking the operands LSB nibble first with a registered carry between steps.

module fulladder (
  input  logic [3:0] i_a,
  input  logic [3:0] i_b,
  input  logic       i_cin,
  output logic [3:0] o_sum,
  output logic       o_cout
);
  always_comb begin
    logic c;
    c     = i_cin;
    o_sum = '0;
    for (int unsigned i = 0; i < 4; i++) begin
      o_sum[i] = i_a[i] ^ i_b[i] ^ c;
      c        = (i_a[i] & i_b[i]) | (c & (i_a[i] ^ i_b[i]));
    end
    o_cout = c;
  end
endmodule

module nibble_add_sequencer #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic             req0_cin,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic             req1_cin,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH-1:0] res_sum,
  output logic             res_cout,
  output logic             res_ovf,
  output logic             res_id,
  output logic             busy
);
  localparam int NIB = WIDTH / 4;
  localparam int IW  = (NIB > 1) ? $clog2(NIB) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           r_state;
  logic [IW-1:0]    r_idx;
  logic             r_carry;
  logic             r_prio;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_sum;
  logic             r_cout;
  logic             r_ovf;
  logic             r_id;
  logic             r_valid;
  logic             r_busy;

  logic             w_gnt0;
  logic             w_gnt1;
  logic             w_hs;
  logic             w_last;
  logic [3:0]       w_nib_a;
  logic [3:0]       w_nib_b;
  logic [3:0]       w_fa_sum;
  logic             w_fa_cout;

  // r_prio=1 means req1 wins a tie; it points away from the last grant.
  assign w_gnt0     = req0_valid & (~req1_valid | ~r_prio);
  assign w_gnt1     = req1_valid & (~req0_valid |  r_prio);
  assign req0_ready = (r_state == IDLE) & w_gnt0;
  assign req1_ready = (r_state == IDLE) & w_gnt1;
  assign w_hs       = req0_ready | req1_ready;

  assign w_last  = (r_idx == IW'(NIB - 1));
  assign w_nib_a = r_a[{r_idx, 2'b00} +: 4];
  assign w_nib_b = r_b[{r_idx, 2'b00} +: 4];

  fulladder u_slice (
    .i_a    (w_nib_a),
    .i_b    (w_nib_b),
    .i_cin  (r_carry),
    .o_sum  (w_fa_sum),
    .o_cout (w_fa_cout)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_idx   <= '0;
      r_carry <= 1'b0;
      r_prio  <= 1'b0;
      r_a     <= '0;
      r_b     <= '0;
      r_sum   <= '0;
      r_cout  <= 1'b0;
      r_ovf   <= 1'b0;
      r_id    <= 1'b0;
      r_valid <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_hs) begin
            r_a     <= w_gnt1 ? req1_a   : req0_a;
            r_b     <= w_gnt1 ? req1_b   : req0_b;
            r_carry <= w_gnt1 ? req1_cin : req0_cin;
            r_id    <= w_gnt1;
            r_prio  <= ~w_gnt1;
            r_idx   <= '0;
            r_busy  <= 1'b1;
            r_state <= RUN;
          end
        end
        RUN: begin
          r_sum[{r_idx, 2'b00} +: 4] <= w_fa_sum;
          r_carry                    <= w_fa_cout;
          if (w_last) begin
            r_cout  <= w_fa_cout;
            r_ovf   <= (r_a[WIDTH-1] ~^ r_b[WIDTH-1]) & (w_fa_sum[3] ^ r_a[WIDTH-1]);
            r_valid <= 1'b1;
            r_state <= DONE;
          end else begin
            r_idx <= r_idx + 1'b1;
          end
        end
        DONE: begin
          if (res_ready) begin
            r_valid <= 1'b0;
            r_busy  <= 1'b0;
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign res_valid = r_valid;
  assign res_sum   = r_sum;
  assign res_cout  = r_cout;
  assign res_ovf   = r_ovf;
  assign res_id    = r_id;
  assign busy      = r_busy;
endmodule

// File: tb/tb_nibble_add_sequencer.sv
// Directed bench for nibble_add_sequencer: arithmetic, arbitration, backpressure, reset.

module tb_nibble_add_sequencer;
  logic        clk;
  logic        rst_n;
  logic        req0_valid, req0_ready, req0_cin;
  logic [15:0] req0_a, req0_b;
  logic        req1_valid, req1_ready, req1_cin;
  logic [15:0] req1_a, req1_b;
  logic        res_valid, res_ready, res_cout, res_ovf, res_id, busy;
  logic [15:0] res_sum;

  int checks = 0;
  int errors = 0;

  nibble_add_sequencer #(.WIDTH(16)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req0_valid (req0_valid),
    .req0_ready (req0_ready),
    .req0_a     (req0_a),
    .req0_b     (req0_b),
    .req0_cin   (req0_cin),
    .req1_valid (req1_valid),
    .req1_ready (req1_ready),
    .req1_a     (req1_a),
    .req1_b     (req1_b),
    .req1_cin   (req1_cin),
    .res_valid  (res_valid),
    .res_ready  (res_ready),
    .res_sum    (res_sum),
    .res_cout   (res_cout),
    .res_ovf    (res_ovf),
    .res_id     (res_id),
    .busy       (busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout want completion");
    $fatal(1);
  end

  // Drives one request, waits for its accept, then counts edges until res_valid.
  task automatic run_op(input bit id, input logic [15:0] a, input logic [15:0] b,
                        input logic cin, output int lat, output bit ok);
    int w;
    ok  = 1'b0;
    lat = 0;
    w   = 0;
    if (id) begin
      req1_a = a; req1_b = b; req1_cin = cin; req1_valid = 1'b1;
    end else begin
      req0_a = a; req0_b = b; req0_cin = cin; req0_valid = 1'b1;
    end
    #1;
    while (!(id ? req1_ready : req0_ready) && w < 20) begin
      @(posedge clk); #1; w++;
    end
    if (w >= 20) begin
      if (id) req1_valid = 1'b0; else req0_valid = 1'b0;
      return;
    end
    @(posedge clk); #1;
    if (id) req1_valid = 1'b0; else req0_valid = 1'b0;
    while (!res_valid && lat < 20) begin
      @(posedge clk); #1; lat++;
    end
    ok = res_valid;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #1;
    checks++;
    if ({req0_ready, req1_ready, res_valid, res_sum, res_cout, res_ovf, res_id, busy} !== 22'd0) begin
      errors++;
      $display("FAIL reset_outputs got %h want 0",
               {req0_ready, req1_ready, res_valid, res_sum, res_cout, res_ovf, res_id, busy});
    end
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    checks++;
    if ({res_valid, res_sum, busy} !== 18'd0) begin
      errors++;
      $display("FAIL reset_release got %h want 0", {res_valid, res_sum, busy});
    end
  endtask

  task automatic test_single();
    int lat; bit ok;
    run_op(1'b0, 16'h1234, 16'h0FFF, 1'b0, lat, ok);
    checks++;
    if (!ok || lat !== 4) begin errors++; $display("FAIL single_latency got %0d (ok=%0d) want 4", lat, ok); end
    checks++;
    if (res_sum !== 16'h2233) begin errors++; $display("FAIL single_sum got %h want 2233", res_sum); end
    checks++;
    if ({res_cout, res_ovf, res_id} !== 3'b000) begin
      errors++; $display("FAIL single_flags got %b want 000", {res_cout, res_ovf, res_id});
    end
    @(posedge clk); #1;
    checks++;
    if (res_valid !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL single_release got valid=%b busy=%b want 0 0", res_valid, busy);
    end
  endtask

  task automatic test_ripple();
    int lat; bit ok;
    run_op(1'b0, 16'hFFFF, 16'h0000, 1'b1, lat, ok);
    checks++;
    if (!ok || res_sum !== 16'h0000) begin errors++; $display("FAIL ripple_sum got %h (ok=%0d) want 0000", res_sum, ok); end
    checks++;
    if ({res_cout, res_ovf} !== 2'b10) begin errors++; $display("FAIL ripple_flags got %b want 10", {res_cout, res_ovf}); end
  endtask

  task automatic test_overflow();
    int lat; bit ok;
    run_op(1'b0, 16'h7FFF, 16'h0001, 1'b0, lat, ok);
    checks++;
    if (!ok || res_sum !== 16'h8000) begin errors++; $display("FAIL ovf_pos_sum got %h (ok=%0d) want 8000", res_sum, ok); end
    checks++;
    if ({res_cout, res_ovf} !== 2'b01) begin errors++; $display("FAIL ovf_pos_flags got %b want 01", {res_cout, res_ovf}); end
    run_op(1'b0, 16'h8000, 16'h8000, 1'b0, lat, ok);
    checks++;
    if (!ok || res_sum !== 16'h0000) begin errors++; $display("FAIL ovf_neg_sum got %h (ok=%0d) want 0000", res_sum, ok); end
    checks++;
    if ({res_cout, res_ovf} !== 2'b11) begin errors++; $display("FAIL ovf_neg_flags got %b want 11", {res_cout, res_ovf}); end
  endtask

  task automatic test_fairness();
    bit g[4];
    int ng = 0;
    int cyc = 0;
    int c0 = 0;
    int c1 = 0;
    int n = 0;
    bit both = 1'b0;
    rst_n = 1'b0;
    #1 rst_n = 1'b1;
    req0_a = 16'h0001; req0_b = 16'h0002; req0_cin = 1'b0;
    req1_a = 16'h0010; req1_b = 16'h0020; req1_cin = 1'b0;
    req0_valid = 1'b1; req1_valid = 1'b1; res_ready = 1'b1;
    #1;
    while (ng < 4 && cyc < 60) begin
      if (req0_ready && req1_ready) both = 1'b1;
      if (req0_ready || req1_ready) begin
        g[ng] = req1_ready;
        if (ng == 0) c0 = cyc;
        if (ng == 1) c1 = cyc;
        ng++;
      end
      @(posedge clk); #1; cyc++;
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    while (busy && n < 20) begin @(posedge clk); #1; n++; end
    checks++;
    if (ng !== 4) begin errors++; $display("FAIL fair_count got %0d want 4", ng); end
    checks++;
    if ({g[0], g[1], g[2], g[3]} !== 4'b0101) begin
      errors++; $display("FAIL fair_order got %b want 0101", {g[0], g[1], g[2], g[3]});
    end
    checks++;
    if (both !== 1'b0) begin errors++; $display("FAIL fair_onehot got both=%b want 0", both); end
    checks++;
    if (c1 - c0 !== 6) begin errors++; $display("FAIL fair_spacing got %0d want 6", c1 - c0); end
  endtask

  task automatic test_backpressure();
    int lat; bit ok;
    bit stable = 1'b1;
    int n = 0;
    res_ready = 1'b0;
    run_op(1'b0, 16'h00FF, 16'h0001, 1'b0, lat, ok);
    checks++;
    if (!ok || lat !== 4 || res_sum !== 16'h0100) begin
      errors++; $display("FAIL bp_result got sum=%h lat=%0d ok=%0d want 0100 4 1", res_sum, lat, ok);
    end
    req1_a = 16'h0003; req1_b = 16'h0004; req1_cin = 1'b0; req1_valid = 1'b1;
    #1;
    repeat (10) begin
      if (!res_valid || res_sum !== 16'h0100 || res_cout || res_ovf || res_id || req0_ready || req1_ready || !busy)
        stable = 1'b0;
      @(posedge clk); #1;
    end
    checks++;
    if (stable !== 1'b1) begin errors++; $display("FAIL bp_hold got stable=%b want 1", stable); end
    res_ready = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (req1_ready !== 1'b1 || res_valid !== 1'b0) begin
      errors++; $display("FAIL bp_resume got ready1=%b valid=%b want 1 0", req1_ready, res_valid);
    end
    @(posedge clk); #1;
    req1_valid = 1'b0;
    while (!res_valid && n < 20) begin @(posedge clk); #1; n++; end
    checks++;
    if (res_valid !== 1'b1 || res_sum !== 16'h0007 || res_id !== 1'b1) begin
      errors++; $display("FAIL bp_req1 got valid=%b sum=%h id=%b want 1 0007 1", res_valid, res_sum, res_id);
    end
  endtask

  task automatic test_reset_mid_run();
    int lat; bit ok;
    int w = 0;
    bit seen = 1'b0;
    req0_a = 16'h5555; req0_b = 16'h5555; req0_cin = 1'b0; req0_valid = 1'b1;
    #1;
    while (!req0_ready && w < 20) begin @(posedge clk); #1; w++; end
    @(posedge clk); #1;
    req0_valid = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({req0_ready, req1_ready, res_valid, res_sum, res_cout, res_ovf, res_id, busy} !== 22'd0) begin
      errors++;
      $display("FAIL midrst_outputs got %h want 0",
               {req0_ready, req1_ready, res_valid, res_sum, res_cout, res_ovf, res_id, busy});
    end
    repeat (3) begin @(posedge clk); #1; if (res_valid) seen = 1'b1; end
    checks++;
    if (seen !== 1'b0) begin errors++; $display("FAIL midrst_novalid got %b want 0", seen); end
    rst_n = 1'b1;
    req1_a = 16'h0000; req1_b = 16'h0000; req1_cin = 1'b0;
    req0_valid = 1'b1; req1_valid = 1'b1;
    #1;
    checks++;
    if ({req0_ready, req1_ready} !== 2'b10) begin
      errors++; $display("FAIL midrst_prio got %b want 10", {req0_ready, req1_ready});
    end
    run_op(1'b0, 16'hABCD, 16'h1111, 1'b1, lat, ok);
    req1_valid = 1'b0;
    checks++;
    if (!ok || lat !== 4 || res_sum !== 16'hBCDF) begin
      errors++; $display("FAIL midrst_op got sum=%h lat=%0d ok=%0d want BCDF 4 1", res_sum, lat, ok);
    end
    checks++;
    if ({res_cout, res_ovf, res_id} !== 3'b000) begin
      errors++; $display("FAIL midrst_flags got %b want 000", {res_cout, res_ovf, res_id});
    end
  endtask

  initial begin
    rst_n = 1'b0;
    req0_valid = 1'b0; req0_a = '0; req0_b = '0; req0_cin = 1'b0;
    req1_valid = 1'b0; req1_a = '0; req1_b = '0; req1_cin = 1'b0;
    res_ready = 1'b1;
    test_reset();
    test_single();
    test_ripple();
    test_overflow();
    test_fairness();
    test_backpressure();
    test_reset_mid_run();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
